// File: rtl/ps2_mouse_tracker.sv
// ps2_mouse_tracker
// Turns the stream of 3-byte PS/2 mouse packets into an absolute cursor position, clamped to the
// screen, plus level button outputs.
//
// Ports:
//   clk, reset          system clock; synchronous active-high reset
//   rx_valid, rx_data   one-cycle byte strobe and byte from the PS/2 receiver
//   x, y                cursor column/row (0,0 = top-left), clamped to the screen
//   button_left/right/middle  button levels, updated only when a packet completes
//   packet_done         one-cycle pulse: x/y/buttons just updated
//   sync_error          one-cycle pulse: bad status byte dropped or partial packet timed out
module ps2_mouse_tracker #(
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480,
  parameter int unsigned X_W      = 10,
  parameter int unsigned Y_W      = 9,
  parameter int unsigned INIT_X   = 320,
  parameter int unsigned INIT_Y   = 240,
  parameter int unsigned TIMEOUT  = 100000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rx_valid,
  input  logic [7:0]     rx_data,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           button_left,
  output logic           button_right,
  output logic           button_middle,
  output logic           packet_done,
  output logic           sync_error
);

  // Two spare bits of headroom so the signed sum never wraps before clamping.
  localparam int unsigned AW = ((X_W > Y_W) ? X_W : Y_W) + 2;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StByte0, StByte1, StByte2} state_e;

  state_e         state_q, state_d;
  // Status byte minus the always-one sync bit: {yovf, xovf, ysign, xsign, m, r, l}.
  logic [6:0]     status_q, status_d;
  logic [7:0]     dx_lo_q, dx_lo_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [2:0]     btn_q, btn_d;
  logic           packet_done_q, packet_done_d;
  logic           sync_error_q, sync_error_d;

  logic [8:0]     dx9, dy9;
  logic [AW-1:0]  dx_ext, dy_ext, x_ext, y_ext, x_sum, y_sum;
  logic [X_W-1:0] x_new;
  logic [Y_W-1:0] y_new;

  // New position from the latched status/dx and the third byte currently on rx_data.
  always_comb begin
    dx9    = status_q[5] ? 9'd0 : {status_q[3], dx_lo_q};
    dy9    = status_q[6] ? 9'd0 : {status_q[4], rx_data};
    dx_ext = {{(AW-9){dx9[8]}}, dx9};
    dy_ext = {{(AW-9){dy9[8]}}, dy9};
    x_ext  = {{(AW-X_W){1'b0}}, x_q};
    y_ext  = {{(AW-Y_W){1'b0}}, y_q};
    x_sum  = x_ext + dx_ext;
    // PS/2 reports +dy as upward motion, screen rows grow downward.
    y_sum  = y_ext - dy_ext;

    if (x_sum[AW-1]) begin
      x_new = '0;
    end else if (x_sum > AW'(SCREEN_W - 1)) begin
      x_new = X_W'(SCREEN_W - 1);
    end else begin
      x_new = x_sum[X_W-1:0];
    end

    if (y_sum[AW-1]) begin
      y_new = '0;
    end else if (y_sum > AW'(SCREEN_H - 1)) begin
      y_new = Y_W'(SCREEN_H - 1);
    end else begin
      y_new = y_sum[Y_W-1:0];
    end
  end

  always_comb begin
    state_d       = state_q;
    status_d      = status_q;
    dx_lo_d       = dx_lo_q;
    timer_d       = '0;
    x_d           = x_q;
    y_d           = y_q;
    btn_d         = btn_q;
    packet_done_d = 1'b0;
    sync_error_d  = 1'b0;

    case (state_q)
      StByte0: begin
        if (rx_valid) begin
          if (rx_data[3]) begin
            status_d = {rx_data[7:4], rx_data[2:0]};
            state_d  = StByte1;
          end else begin
            // Not a status byte: drop it and keep hunting for one.
            sync_error_d = 1'b1;
          end
        end
      end
      StByte1, StByte2: begin
        if (rx_valid) begin
          // An arriving byte beats a simultaneous timeout.
          if (state_q == StByte1) begin
            dx_lo_d = rx_data;
            state_d = StByte2;
          end else begin
            x_d           = x_new;
            y_d           = y_new;
            btn_d         = status_q[2:0];
            packet_done_d = 1'b1;
            state_d       = StByte0;
          end
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          // This idle cycle brings the gap to TIMEOUT: abandon the packet.
          sync_error_d = 1'b1;
          state_d      = StByte0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = StByte0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StByte0;
      status_q      <= '0;
      dx_lo_q       <= '0;
      timer_q       <= '0;
      x_q           <= X_W'(INIT_X);
      y_q           <= Y_W'(INIT_Y);
      btn_q         <= '0;
      packet_done_q <= 1'b0;
      sync_error_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      status_q      <= status_d;
      dx_lo_q       <= dx_lo_d;
      timer_q       <= timer_d;
      x_q           <= x_d;
      y_q           <= y_d;
      btn_q         <= btn_d;
      packet_done_q <= packet_done_d;
      sync_error_q  <= sync_error_d;
    end
  end

  assign x             = x_q;
  assign y             = y_q;
  assign button_left   = btn_q[0];
  assign button_right  = btn_q[1];
  assign button_middle = btn_q[2];
  assign packet_done   = packet_done_q;
  assign sync_error    = sync_error_q;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Directed bench for ps2_mouse_tracker: a per-cycle vector table (inputs plus the outputs
// expected just after that clock edge) and hand-written gap/timeout sequences.
module tb_ps2_mouse_tracker;

  localparam int unsigned TO = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [9:0] x;
  logic [8:0] y;
  logic       button_left, button_right, button_middle, packet_done, sync_error;

  ps2_mouse_tracker #(
    .TIMEOUT(TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .x            (x),
    .y            (y),
    .button_left  (button_left),
    .button_right (button_right),
    .button_middle(button_middle),
    .packet_done  (packet_done),
    .sync_error   (sync_error)
  );

  always #5 clk = ~clk;

  // eb is {middle, right, left}.
  typedef struct packed {
    logic       rst;
    logic       vld;
    logic [7:0] data;
    logic [9:0] ex;
    logic [8:0] ey;
    logic [2:0] eb;
    logic       epd;
    logic       ese;
  } vec_t;

  vec_t  vecs[$];
  string names[$];
  int    n_vec = 0;
  int    n_bad = 0;

  function automatic void add(string name, logic rst, logic vld, logic [7:0] data, int ex,
                              int ey, logic [2:0] eb, logic epd, logic ese);
    vec_t v;
    v.rst  = rst;
    v.vld  = vld;
    v.data = data;
    v.ex   = 10'(ex);
    v.ey   = 9'(ey);
    v.eb   = eb;
    v.epd  = epd;
    v.ese  = ese;
    vecs.push_back(v);
    names.push_back(name);
  endfunction

  // One clock: drive inputs, take the edge, sample 1 time unit later.
  task automatic step(input logic r, input logic v, input logic [7:0] d);
    reset    = r;
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic check(input string name, input int ex, input int ey, input logic [2:0] eb,
                       input logic epd, input logic ese);
    n_vec++;
    if (x !== 10'(ex) || y !== 9'(ey) || {button_middle, button_right, button_left} !== eb ||
        packet_done !== epd || sync_error !== ese) begin
      n_bad++;
      $display("FAIL %s: got x=%0d y=%0d mrl=%b pd=%b se=%b, want x=%0d y=%0d mrl=%b pd=%b se=%b",
               name, x, y, {button_middle, button_right, button_left}, packet_done, sync_error,
               ex, ey, eb, epd, ese);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_se, n_pd, first_se;

    // Reset and a basic packet: L pressed, dx=+5, dy=+3 (up).
    add("rst",      1, 0, 8'h00, 320, 240, 3'b000, 0, 0);
    add("idle",     0, 0, 8'h00, 320, 240, 3'b000, 0, 0);
    add("p1_b0",    0, 1, 8'h09, 320, 240, 3'b000, 0, 0);
    add("p1_b1",    0, 1, 8'h05, 320, 240, 3'b000, 0, 0);
    add("p1_b2",    0, 1, 8'h03, 325, 237, 3'b001, 1, 0);
    add("p1_hold",  0, 0, 8'h00, 325, 237, 3'b001, 0, 0);
    // R pressed, dx=-10, dy=-2.
    add("p2_rst",   1, 0, 8'h00, 320, 240, 3'b000, 0, 0);
    add("p2_b0",    0, 1, 8'h3A, 320, 240, 3'b000, 0, 0);
    add("p2_b1",    0, 1, 8'hF6, 320, 240, 3'b000, 0, 0);
    add("p2_b2",    0, 1, 8'hFE, 310, 242, 3'b010, 1, 0);
    add("p2_hold",  0, 0, 8'h00, 310, 242, 3'b010, 0, 0);
    // Right-edge clamp with back-to-back packets, overflow, bottom-edge clamp.
    add("c_rst",    1, 0, 8'h00, 320, 240, 3'b000, 0, 0);
    for (int k = 0; k < 4; k++) begin
      int xe;
      xe = (k == 0) ? 447 : (k == 1) ? 574 : 639;
      add("c_xb0",  0, 1, 8'h08, (k == 0) ? 320 : (k == 1) ? 447 : (k == 2) ? 574 : 639, 240,
          3'b000, 0, 0);
      add("c_xb1",  0, 1, 8'h7F, (k == 0) ? 320 : (k == 1) ? 447 : (k == 2) ? 574 : 639, 240,
          3'b000, 0, 0);
      add("c_xb2",  0, 1, 8'h00, xe, 240, 3'b000, 1, 0);
    end
    add("ov_b0",    0, 1, 8'h48, 639, 240, 3'b000, 0, 0);
    add("ov_b1",    0, 1, 8'h20, 639, 240, 3'b000, 0, 0);
    add("ov_b2",    0, 1, 8'h00, 639, 240, 3'b000, 1, 0);
    add("y1_b0",    0, 1, 8'h28, 639, 240, 3'b000, 0, 0);
    add("y1_b1",    0, 1, 8'h00, 639, 240, 3'b000, 0, 0);
    add("y1_b2",    0, 1, 8'h81, 639, 367, 3'b000, 1, 0);
    add("y2_b0",    0, 1, 8'h28, 639, 367, 3'b000, 0, 0);
    add("y2_b1",    0, 1, 8'h00, 639, 367, 3'b000, 0, 0);
    add("y2_b2",    0, 1, 8'h81, 639, 479, 3'b000, 1, 0);
    add("y_hold",   0, 0, 8'h00, 639, 479, 3'b000, 0, 0);
    // Resync on a byte without bit3 set.
    add("rs_rst",   1, 0, 8'h00, 320, 240, 3'b000, 0, 0);
    add("rs_drop",  0, 1, 8'h05, 320, 240, 3'b000, 0, 1);
    add("rs_idle",  0, 0, 8'h00, 320, 240, 3'b000, 0, 0);
    add("rs_b0",    0, 1, 8'h0A, 320, 240, 3'b000, 0, 0);
    add("rs_b1",    0, 1, 8'h01, 320, 240, 3'b000, 0, 0);
    add("rs_b2",    0, 1, 8'h01, 321, 239, 3'b010, 1, 0);
    // Reset mid-packet overrides a coincident byte; next three bytes are a fresh packet.
    add("mr_b0",    0, 1, 8'h09, 321, 239, 3'b010, 0, 0);
    add("mr_b1",    0, 1, 8'h05, 321, 239, 3'b010, 0, 0);
    add("mr_rst",   1, 1, 8'h03, 320, 240, 3'b000, 0, 0);
    add("mr_f0",    0, 1, 8'h09, 320, 240, 3'b000, 0, 0);
    add("mr_f1",    0, 1, 8'h05, 320, 240, 3'b000, 0, 0);
    add("mr_f2",    0, 1, 8'h03, 325, 237, 3'b001, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].vld, vecs[i].data);
      check(names[i], int'(vecs[i].ex), int'(vecs[i].ey), vecs[i].eb, vecs[i].epd,
            vecs[i].ese);
    end

    // Timeout: two bytes then silence; exactly one sync_error after TO idle cycles.
    step(1'b1, 1'b0, 8'h00);
    check("to_rst", 320, 240, 3'b000, 0, 0);
    step(1'b0, 1'b1, 8'h08);
    step(1'b0, 1'b1, 8'h10);
    n_se = 0;
    n_pd = 0;
    first_se = -1;
    for (int i = 1; i <= int'(TO) + 5; i++) begin
      step(1'b0, 1'b0, 8'h00);
      if (sync_error) begin
        n_se++;
        if (first_se < 0) first_se = i;
      end
      if (packet_done) n_pd++;
    end
    check_int("to_se_count", n_se, 1);
    check_int("to_se_cycle", first_se, int'(TO));
    check_int("to_pd_count", n_pd, 0);
    check("to_unchanged", 320, 240, 3'b000, 0, 0);
    step(1'b0, 1'b1, 8'h09);
    step(1'b0, 1'b1, 8'h01);
    step(1'b0, 1'b1, 8'h01);
    check("to_next_pkt", 321, 239, 3'b001, 1, 0);

    // Gaps just under the timeout between every byte: each byte clears the timer.
    step(1'b1, 1'b0, 8'h00);
    n_se = 0;
    step(1'b0, 1'b1, 8'h08);
    for (int i = 0; i < int'(TO) - 2; i++) begin
      step(1'b0, 1'b0, 8'h00);
      if (sync_error) n_se++;
    end
    step(1'b0, 1'b1, 8'h01);
    for (int i = 0; i < int'(TO) - 2; i++) begin
      step(1'b0, 1'b0, 8'h00);
      if (sync_error) n_se++;
    end
    step(1'b0, 1'b1, 8'h01);
    check("gap_pkt", 321, 239, 3'b000, 1, 0);
    check_int("gap_se_count", n_se, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
